// File: rtl/conv_window_serializer.sv
// Buffers a raster pixel stream in a 3-row circular line buffer and serializes every
// complete 3x3 window as 9 (pixel, weight) pairs. Define CONV_WIN_CNT_EN to add o_win_cnt.
module conv_window_serializer #(
  parameter int WIDTH = 32,
  parameter int IMG_W = 8,
  parameter int IMG_H = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_wt_valid,
  input  logic [WIDTH-1:0] i_wt_data,
  input  logic             i_pix_valid,
  input  logic [WIDTH-1:0] i_pix_data,
  output logic             o_pix_ready,
  output logic [WIDTH-1:0] o_pixel,
  output logic [WIDTH-1:0] o_weight,
  output logic             o_valid,
  output logic             o_first,
  output logic             o_last,
  output logic             o_frame_done
`ifdef CONV_WIN_CNT_EN
  ,
  output logic [15:0]      o_win_cnt
`endif
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  typedef enum logic {ACCEPT, SER} state_t;

  state_t           state;
  logic [RW-1:0]    row;
  logic [CW-1:0]    col;
  logic [1:0]       row_slot;
  logic [3:0]       k;
  logic [3:0]       wt_ptr;
  logic [WIDTH-1:0] wt [9];
  logic [WIDTH-1:0] line_buf [3][IMG_W];
  logic [1:0]       tap_slot;
  logic [1:0]       tap_c;
  logic [CW-1:0]    tap_col;
  logic [CW-1:0]    win_col;
  logic             win_is_final;

  logic pix_take;
  logic win_done;

  assign pix_take = i_pix_valid && o_pix_ready;
  assign win_done = pix_take && (row >= RW'(2)) && (col >= CW'(2));

  // NOTE: the line buffer has no reset; after any reset every slot a window reads is
  // rewritten by the new frame before it is used.
  always_ff @(posedge clk) begin
    if (pix_take) line_buf[row_slot][col] <= i_pix_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ACCEPT;
      row          <= '0;
      col          <= '0;
      row_slot     <= '0;
      k            <= '0;
      wt_ptr       <= '0;
      for (int i = 0; i < 9; i++) wt[i] <= '0;
      tap_slot     <= '0;
      tap_c        <= '0;
      tap_col      <= '0;
      win_col      <= '0;
      win_is_final <= 1'b0;
      o_pix_ready  <= 1'b1;
      o_pixel      <= '0;
      o_weight     <= '0;
      o_valid      <= 1'b0;
      o_first      <= 1'b0;
      o_last       <= 1'b0;
      o_frame_done <= 1'b0;
    end else begin
      case (state)
        ACCEPT: begin
          o_valid      <= 1'b0;
          o_first      <= 1'b0;
          o_last       <= 1'b0;
          o_frame_done <= 1'b0;
          o_pixel      <= '0;
          o_weight     <= '0;
          if (i_wt_valid) begin
            wt[wt_ptr] <= i_wt_data;
            wt_ptr     <= (wt_ptr == 4'd8) ? 4'd0 : wt_ptr + 4'd1;
          end
          if (pix_take) begin
            if (col == COL_LAST) begin
              col <= '0;
              if (row == ROW_LAST) begin
                row      <= '0;
                row_slot <= '0;
              end else begin
                row      <= row + 1'b1;
                row_slot <= (row_slot == 2'd2) ? 2'd0 : row_slot + 2'd1;
              end
            end else begin
              col <= col + 1'b1;
            end
          end
          // Latch the window geometry now: row/col move on before the burst reads it.
          if (win_done) begin
            state        <= SER;
            o_pix_ready  <= 1'b0;
            k            <= '0;
            tap_c        <= '0;
            tap_slot     <= (row_slot == 2'd2) ? 2'd0 : row_slot + 2'd1;
            win_col      <= col - CW'(2);
            tap_col      <= col - CW'(2);
            win_is_final <= (row == ROW_LAST) && (col == COL_LAST);
          end
        end

        SER: begin
          o_valid      <= 1'b1;
          o_first      <= (k == 4'd0);
          o_last       <= (k == 4'd8);
          o_frame_done <= (k == 4'd8) && win_is_final;
          o_pixel      <= line_buf[tap_slot][tap_col];
          o_weight     <= wt[k];
          if (tap_c == 2'd2) begin
            tap_c    <= '0;
            tap_col  <= win_col;
            tap_slot <= (tap_slot == 2'd2) ? 2'd0 : tap_slot + 2'd1;
          end else begin
            tap_c   <= tap_c + 2'd1;
            tap_col <= tap_col + 1'b1;
          end
          if (k == 4'd8) begin
            state       <= ACCEPT;
            o_pix_ready <= 1'b1;
            k           <= '0;
          end else begin
            k <= k + 4'd1;
          end
        end

        default: state <= ACCEPT;
      endcase
    end
  end

`ifdef CONV_WIN_CNT_EN
  // Counts windows in the current frame; cleared the cycle after the frame's last window.
  always_ff @(posedge clk) begin
    if (rst || o_frame_done) begin
      o_win_cnt <= '0;
    end else if (state == SER && k == 4'd8 && o_win_cnt != 16'hFFFF) begin
      o_win_cnt <= o_win_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_conv_window_serializer.sv
// Randomized scoreboard bench for conv_window_serializer: a 3x3 and a 4x3 instance,
// each checked against a frame-array reference model of windows and handshake timing.
module tb_conv_window_serializer;

  localparam int NDUT = 2;

  typedef struct packed {
    logic [31:0] pix;
    logic [31:0] wt;
    logic        first;
    logic        last;
    logic        fd;
    logic [31:0] cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst       [NDUT];
  logic        wt_valid  [NDUT];
  logic [31:0] wt_data   [NDUT];
  logic        pix_valid [NDUT];
  logic [31:0] pix_data  [NDUT];
  logic        pix_ready [NDUT];
  logic [31:0] pixel     [NDUT];
  logic [31:0] weight    [NDUT];
  logic        valid     [NDUT];
  logic        first     [NDUT];
  logic        last      [NDUT];
  logic        fdone     [NDUT];
`ifdef CONV_WIN_CNT_EN
  logic [15:0] win_cnt   [NDUT];
`endif

  always #5 clk = ~clk;

  conv_window_serializer #(.WIDTH(32), .IMG_W(3), .IMG_H(3)) u_dut3 (
    .clk(clk), .rst(rst[0]),
    .i_wt_valid(wt_valid[0]), .i_wt_data(wt_data[0]),
    .i_pix_valid(pix_valid[0]), .i_pix_data(pix_data[0]), .o_pix_ready(pix_ready[0]),
    .o_pixel(pixel[0]), .o_weight(weight[0]), .o_valid(valid[0]),
    .o_first(first[0]), .o_last(last[0]), .o_frame_done(fdone[0])
`ifdef CONV_WIN_CNT_EN
    , .o_win_cnt(win_cnt[0])
`endif
  );

  conv_window_serializer #(.WIDTH(32), .IMG_W(4), .IMG_H(3)) u_dut4 (
    .clk(clk), .rst(rst[1]),
    .i_wt_valid(wt_valid[1]), .i_wt_data(wt_data[1]),
    .i_pix_valid(pix_valid[1]), .i_pix_data(pix_data[1]), .o_pix_ready(pix_ready[1]),
    .o_pixel(pixel[1]), .o_weight(weight[1]), .o_valid(valid[1]),
    .o_first(first[1]), .o_last(last[1]), .o_frame_done(fdone[1])
`ifdef CONV_WIN_CNT_EN
    , .o_win_cnt(win_cnt[1])
`endif
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  int          ncyc     = 0;
  bit          mon_en   = 1'b0;
  exp_t        exp_q     [NDUT][$];
  int          low_until [NDUT];
  logic [31:0] m_wt      [NDUT][9];
  int          m_ptr     [NDUT];
  int          m_pix_n   [NDUT];
  logic [31:0] m_frame   [NDUT][16];
  int          exp_cnt   [NDUT];
  bit          pend_clr  [NDUT];
  logic [31:0] fl        [9];

  function automatic int img_w(input int d);
    return (d == 0) ? 3 : 4;
  endfunction

  function automatic int img_h(input int d);
    return 3;
  endfunction

  task automatic check(input string name, input int d, input logic [31:0] act,
                       input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s dut%0d cycle %0d: got %h expected %h", name, d, ncyc, act, expv);
    end
  endtask

  // Monitor: pops the scoreboard whenever a DUT presents a tap; checks idle outputs and ready.
  always @(negedge clk) begin : monitor
    exp_t e;
    bit   popped;
    ncyc++;
    if (mon_en) begin
      for (int d = 0; d < NDUT; d++) begin
        popped = 1'b0;
        e      = '0;
        check("pix_ready", d, {31'b0, pix_ready[d]}, {31'b0, (ncyc > low_until[d])});
        if (valid[d] === 1'b1) begin
          if (exp_q[d].size() == 0) begin
            check("unexpected_tap", d, {31'b0, valid[d]}, 32'd0);
          end else begin
            e      = exp_q[d].pop_front();
            popped = 1'b1;
            check("tap_cycle", d, ncyc, e.cyc);
            check("tap_pixel", d, pixel[d], e.pix);
            check("tap_weight", d, weight[d], e.wt);
            check("tap_first", d, {31'b0, first[d]}, {31'b0, e.first});
            check("tap_last", d, {31'b0, last[d]}, {31'b0, e.last});
            check("tap_frame_done", d, {31'b0, fdone[d]}, {31'b0, e.fd});
          end
        end else begin
          check("idle_valid", d, {31'b0, valid[d]}, 32'd0);
          check("idle_pixel", d, pixel[d], 32'd0);
          check("idle_weight", d, weight[d], 32'd0);
          check("idle_flags", d, {29'b0, first[d], last[d], fdone[d]}, 32'd0);
        end
`ifdef CONV_WIN_CNT_EN
        if (pend_clr[d]) begin
          exp_cnt[d]  = 0;
          pend_clr[d] = 1'b0;
        end
        if (popped && e.last) begin
          if (exp_cnt[d] < 65535) exp_cnt[d]++;
          pend_clr[d] = e.fd;
        end
        check("win_cnt", d, {16'b0, win_cnt[d]}, exp_cnt[d]);
`endif
      end
    end
  end

  task automatic reset_model(input int d);
    for (int i = 0; i < 9; i++) m_wt[d][i] = '0;
    m_ptr[d]     = 0;
    m_pix_n[d]   = 0;
    exp_q[d].delete();
    low_until[d] = ncyc;
    exp_cnt[d]   = 0;
    pend_clr[d]  = 1'b0;
  endtask

  // Reference: the frame as a flat array; a window ends at every pixel with row>=2, col>=2.
  task automatic accept_pixel(input int d, input logic [31:0] pd);
    int   w, h, idx, r, c;
    exp_t e;
    w   = img_w(d);
    h   = img_h(d);
    idx = m_pix_n[d];
    m_frame[d][idx] = pd;
    r = idx / w;
    c = idx % w;
    if (r >= 2 && c >= 2) begin
      for (int k = 0; k < 9; k++) begin
        e.pix   = m_frame[d][(r - 2 + k / 3) * w + (c - 2 + k % 3)];
        e.wt    = m_wt[d][k];
        e.first = (k == 0);
        e.last  = (k == 8);
        e.fd    = (k == 8) && (idx == w * h - 1);
        e.cyc   = ncyc + 2 + k;
        exp_q[d].push_back(e);
      end
      low_until[d] = ncyc + 9;
    end
    m_pix_n[d] = (idx + 1) % (w * h);
  endtask

  // One clock of stimulus; rdy reports whether the model expects the inputs to be taken.
  task automatic step(input int d, input bit pv, input logic [31:0] pd, input bit wv,
                      input logic [31:0] wd, input bit do_rst, output bit rdy);
    @(negedge clk);
    #1;
    rst[d]       = do_rst;
    pix_valid[d] = pv;
    pix_data[d]  = pd;
    wt_valid[d]  = wv;
    wt_data[d]   = wd;
    rdy          = 1'b0;
    if (do_rst) begin
      reset_model(d);
    end else if (ncyc > low_until[d]) begin
      rdy = 1'b1;
      if (wv) begin
        m_wt[d][m_ptr[d]] = wd;
        m_ptr[d]          = (m_ptr[d] + 1) % 9;
      end
      if (pv) accept_pixel(d, pd);
    end
  endtask

  task automatic idle(input int d, input int n, input bit rand_wt);
    bit rdy;
    for (int i = 0; i < n; i++)
      step(d, 1'b0, '0, rand_wt && ($urandom_range(0, 3) == 0), $urandom, 1'b0, rdy);
  endtask

  task automatic send_pix(input int d, input logic [31:0] pd, input bit rand_wt);
    bit rdy;
    int tries = 0;
    do begin
      step(d, 1'b1, pd, rand_wt && ($urandom_range(0, 5) == 0), $urandom, 1'b0, rdy);
      tries++;
    end while (!rdy && tries < 40);
  endtask

  task automatic load_wt(input int d, input logic [31:0] wd);
    bit rdy;
    int tries = 0;
    do begin
      step(d, 1'b0, '0, 1'b1, wd, 1'b0, rdy);
      tries++;
    end while (!rdy && tries < 40);
  endtask

  task automatic drain(input int d);
    bit rdy;
    int n = 0;
    while (exp_q[d].size() != 0 && n < 40) begin
      step(d, 1'b0, '0, 1'b0, '0, 1'b0, rdy);
      n++;
    end
    check("drain_timeout", d, exp_q[d].size(), 32'd0);
  endtask

  task automatic random_frames(input int d, input int nframes);
    for (int f = 0; f < nframes; f++) begin
      for (int i = 0; i < img_w(d) * img_h(d); i++) begin
        if ($urandom_range(0, 3) == 0) idle(d, $urandom_range(1, 3), 1'b1);
        send_pix(d, $urandom, 1'b1);
      end
    end
    drain(d);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit rdy;
    fl = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000,
           32'h40C00000, 32'h40E00000, 32'h41000000, 32'h41100000};
    for (int d = 0; d < NDUT; d++) begin
      rst[d] = 1'b1; wt_valid[d] = 1'b0; wt_data[d] = '0;
      pix_valid[d] = 1'b0; pix_data[d] = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    for (int d = 0; d < NDUT; d++) begin
      rst[d] = 1'b0;
      reset_model(d);
    end
    mon_en = 1'b1;

    // 3x3: weights 1.0..9.0, pixels 1.0..9.0 streamed with valid held high.
    for (int i = 0; i < 9; i++) load_wt(0, fl[i]);
    for (int i = 0; i < 9; i++) send_pix(0, fl[i], 1'b0);
    drain(0);
    idle(0, 3, 1'b0);

    // Weight writes during the burst are ignored; ten writes in ACCEPT wrap onto wt[0].
    for (int i = 0; i < 9; i++) send_pix(0, $urandom, 1'b0);
    for (int i = 0; i < 3; i++) step(0, 1'b0, '0, 1'b1, 32'h42280000, 1'b0, rdy);
    drain(0);
    for (int i = 0; i < 9; i++) send_pix(0, $urandom, 1'b0);
    drain(0);
    for (int i = 0; i < 10; i++) load_wt(0, $urandom);
    for (int i = 0; i < 9; i++) send_pix(0, $urandom, 1'b0);
    drain(0);

    // Reset while tap 4 is on the outputs, then fresh frames with zero and reloaded weights.
    for (int i = 0; i < 9; i++) send_pix(0, $urandom, 1'b0);
    idle(0, 5, 1'b0);
    step(0, 1'b0, '0, 1'b0, '0, 1'b1, rdy);
    idle(0, 2, 1'b0);
    for (int i = 0; i < 9; i++) send_pix(0, $urandom, 1'b0);
    drain(0);
    for (int i = 0; i < 9; i++) load_wt(0, $urandom);
    for (int i = 0; i < 9; i++) send_pix(0, $urandom, 1'b0);
    drain(0);

    // Two back-to-back frames with no gap.
    for (int i = 0; i < 18; i++) send_pix(0, $urandom, 1'b0);
    drain(0);
    random_frames(0, 3);

    // 4x3: pixels 1..12 give two bursts; then randomized frames.
    for (int i = 0; i < 9; i++) load_wt(1, fl[i]);
    for (int i = 1; i <= 12; i++) send_pix(1, i, 1'b0);
    drain(1);
    idle(1, 2, 1'b0);
    random_frames(1, 3);

    idle(0, 3, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/conv_window_serializer.md
Name: conv_window_serializer

Overview:
Upstream feeder for conv_kernel. Accepts a raster-order pixel stream and a 9-entry weight load. For every valid 3x3 window (no padding), it emits the 9 (pixel, weight) pairs serially, one per clock. Outputs are zero outside bursts, so conv_kernel can accumulate directly.

Parameters:
WIDTH, 32, data word width (IEEE-754 single; bits passed through untouched)
IMG_W, 8, image width in pixels (>=3)
IMG_H, 8, image height in pixels (>=3)

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
i_wt_valid  input  1  weight write strobe
i_wt_data  input  WIDTH  weight word
i_pix_valid  input  1  pixel present
i_pix_data  input  WIDTH  pixel word, raster order (row-major, top-left first)
o_pix_ready  output  1  pixel accepted on edge where i_pix_valid & o_pix_ready
o_pixel  output  WIDTH  window tap pixel to conv_kernel i_pixel
o_weight  output  WIDTH  matching weight to conv_kernel i_weight
o_valid  output  1  pair on o_pixel/o_weight valid
o_first  output  1  with tap 0 of a window
o_last  output  1  with tap 8 of a window
o_frame_done  output  1  one-cycle pulse, coincident with o_last of the frame's final window

Behaviour:
- Reset (rst high at edge):
  - state=ACCEPT; row/col counters=0; tap counter k=0; weight pointer=0; all 9 weights=0.
  - o_valid/o_first/o_last/o_frame_done=0; o_pixel=o_weight=0; o_pix_ready=1 in the cycle after.
  - Line-buffer contents are not cleared (don't care).
  - Reset mid-burst aborts the burst: no further taps are emitted.
- Weight load:
  - Only in ACCEPT: on i_wt_valid, wt[ptr]<=i_wt_data and ptr<=ptr+1, wrapping 8->0.
  - In SER, i_wt_valid is ignored; ptr is unchanged.
  - Weight and pixel accepted on the same edge are both taken.
  - A new weight applies to windows whose burst starts after it is written.
- Storage: 3-row circular line buffer (3*IMG_W words). The pixel at (row,col) is written to slot [row mod 3][col].
- Counters:
  - col wraps IMG_W-1 -> 0 and increments row.
  - row wraps IMG_H-1 -> 0 after the final pixel (frame end).
- States:
  - ACCEPT: o_pix_ready=1. Accepting a pixel with row>=2 and col>=2 completes the window ending at (row,col) -> go to SER, k=0. Otherwise stay in ACCEPT.
  - SER: o_pix_ready=0. Emit tap k in order window row top->bottom, column left->right.
    - Tap k pixel = pixel at (row-2+k/3, col-2+k%3); weight = wt[k].
    - After k=8, return to ACCEPT.
- Timing:
  - Pixel accepted at edge t completes a window -> taps 0..8 appear registered after edges t+1..t+9 (9 consecutive o_valid cycles).
  - o_first is with tap 0; o_last is with tap 8.
  - o_pix_ready is low after edges t..t+8 and high again after edge t+9.
  - Back-to-back windows are therefore spaced by at least 10 cycles.
- Idle outputs: when o_valid=0, o_pixel and o_weight are driven to 0.
- Frame end: o_frame_done pulses with o_last of window (IMG_H-1, IMG_W-1); counters are already back at 0.
- Window count per frame = (IMG_H-2)*(IMG_W-2). Non-window pixels never stall the stream.

Optional Feature:
CONV_WIN_CNT_EN
- Defined: adds output o_win_cnt [15:0]. It increments on each o_last, reads the running count within the frame, and clears to 0 on the edge after o_frame_done and on rst. It saturates at 16'hFFFF.
- Undefined: port and counter absent; behaviour otherwise identical.

Test Plan:
- IMG_W=IMG_H=3; load weights 1.0..9.0 (3F800000..41100000); stream pixels 1.0..9.0 with i_pix_valid held high -> exactly one burst of pairs (1,1),(2,2)..(9,9); o_first on the 1st pair, o_last and o_frame_done on the 9th. o_pixel/o_weight are 0 before and after the burst.
- IMG_W=4, IMG_H=3; pixels 1..12 -> two bursts. Burst 1 taps = 1,2,3,5,6,7,9,10,11. Burst 2 taps = 2,3,4,6,7,8,10,11,12. o_pix_ready low for 9 cycles after accepting pixels 11 and 12. o_frame_done only with burst 2's o_last.
- IMG_W=IMG_H=3, i_wt_valid pulsed during SER with 42280000 -> wt unchanged, ptr unchanged. Load 10 weights in ACCEPT -> the 10th overwrites wt[0].
- Assert rst while o_valid high at tap k=4 -> next cycle o_valid=0, o_pixel=0, o_pix_ready=1. A full fresh 3x3 frame then yields one correct 9-tap burst (weights must be reloaded; they read 0 after reset).
- Two consecutive 3x3 frames with no gap -> two bursts, two o_frame_done pulses. With CONV_WIN_CNT_EN, o_win_cnt reads 1 then returns to 0 between frames.
